// File: rtl/sfu_pair_sched_pkg.sv
// Shared definitions for the SFU pair scheduler: state encoding and sizing helpers.
package sfu_pair_sched_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Ceiling log2 with a floor of one bit so single-value counters still get a wire.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Number of unordered pairs (i<j) among n candidates.
  function automatic int pair_count(input int n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/sfu_pair_idx_gen.sv
// Pair index generator: walks (i,j) over all i<j and delays each issued pair so
// it lines up with the matching SFU-check response.
module sfu_pair_idx_gen
  import sfu_pair_sched_pkg::*;
#(
  parameter int NUM_ANT  = 8,
  parameter int PIPE_LAT = 1,
  localparam int IW      = clog2(NUM_ANT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          advance_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic          last_o,
  output logic [IW-1:0] rsp_i_o,
  output logic [IW-1:0] rsp_j_o
);

  localparam logic [IW-1:0] LAST_I = IW'(NUM_ANT - 2);
  localparam logic [IW-1:0] LAST_J = IW'(NUM_ANT - 1);

  logic [IW-1:0] i_q, i_d, j_q, j_d;
  // Stage 0 holds the pair currently on the chk_* outputs; stage PIPE_LAT is
  // the pair whose result is on chk_y_valid.
  logic [IW-1:0] pipe_i_q [PIPE_LAT+1];
  logic [IW-1:0] pipe_j_q [PIPE_LAT+1];

  assign last_o  = (i_q == LAST_I) && (j_q == LAST_J);
  assign i_o     = i_q;
  assign j_o     = j_q;
  assign rsp_i_o = pipe_i_q[PIPE_LAT];
  assign rsp_j_o = pipe_j_q[PIPE_LAT];

  // Next pair: wrap j to i+1 when j reaches the last entry; hold on the last pair.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (start_i) begin
      i_d = '0;
      j_d = IW'(1);
    end else if (advance_i && !last_o) begin
      if (j_q == LAST_J) begin
        i_d = i_q + IW'(1);
        j_d = i_q + IW'(2);
      end else begin
        j_d = j_q + IW'(1);
      end
    end
  end

  // Pair counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= IW'(1);
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  // Free-running index delay line aligned to the SFU-check latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= PIPE_LAT; k++) begin
        pipe_i_q[k] <= '0;
        pipe_j_q[k] <= '0;
      end
    end else begin
      pipe_i_q[0] <= i_q;
      pipe_j_q[0] <= j_q;
      for (int k = 1; k <= PIPE_LAT; k++) begin
        pipe_i_q[k] <= pipe_i_q[k-1];
        pipe_j_q[k] <= pipe_j_q[k-1];
      end
    end
  end

endmodule

// File: rtl/sfu_pair_sched.sv
// SFU pair scheduler: loads NUM_ANT candidates, issues every pair to the SFU-check
// stage, and folds the same-SFU flags into a conflict mask and pair count.
// Optional macro SFU_SCHED_TIMEOUT_EN adds a DRAIN timeout that raises err.
module sfu_pair_sched
  import sfu_pair_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 4,
  parameter int NUM_ANT     = 8,
  parameter int PIPE_LAT    = 1,
  parameter int TIMEOUT_CYC = 4,
  localparam int CNT_W      = clog2(pair_count(NUM_ANT) + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [LABEL_WIDTH-1:0] in_label,
  output logic                   chk_valid,
  output logic [DATA_WIDTH-1:0]  chk_x_0,
  output logic [DATA_WIDTH-1:0]  chk_x_1,
  output logic [LABEL_WIDTH-1:0] chk_label_0,
  output logic [LABEL_WIDTH-1:0] chk_label_1,
  input  logic                   chk_y_valid,
  input  logic                   chk_flag_same_sfu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_ANT-1:0]     conflict_mask,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic                   err
);

  localparam int IW = clog2(NUM_ANT);
  localparam logic [IW-1:0]    LAST_LOAD = IW'(NUM_ANT - 1);
  localparam logic [CNT_W-1:0] NUM_PAIRS = CNT_W'(pair_count(NUM_ANT));

  if (NUM_ANT < 2 || PIPE_LAT < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sfu_pair_sched: NUM_ANT >= 2, PIPE_LAT >= 1, TIMEOUT_CYC >= 1 required");
  end

  sched_state_e state_q, state_d;
  logic [IW-1:0]          load_idx_q;
  logic [DATA_WIDTH-1:0]  ent_data_q  [NUM_ANT];
  logic [LABEL_WIDTH-1:0] ent_label_q [NUM_ANT];
  logic                   in_ready_q, out_valid_q, chk_valid_q;
  logic [DATA_WIDTH-1:0]  chk_x_0_q, chk_x_1_q;
  logic [LABEL_WIDTH-1:0] chk_label_0_q, chk_label_1_q;
  logic [CNT_W-1:0]       resp_cnt_q, cnt_q;
  logic [NUM_ANT-1:0]     mask_q;

  logic          beat, last_beat, pair_start, issue, capture, accept;
  logic [IW-1:0] pi, pj, rsp_i, rsp_j;
  logic          last_pair;

  sfu_pair_idx_gen #(
    .NUM_ANT (NUM_ANT),
    .PIPE_LAT(PIPE_LAT)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .start_i  (pair_start),
    .advance_i(issue),
    .i_o      (pi),
    .j_o      (pj),
    .last_o   (last_pair),
    .rsp_i_o  (rsp_i),
    .rsp_j_o  (rsp_j)
  );

  assign beat      = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign last_beat = beat && (load_idx_q == LAST_LOAD);
  assign accept    = (state_q == ST_DONE) && out_valid_q && out_ready;
  // Responses outside ISSUE/DRAIN belong to an aborted round and are dropped.
  assign capture   = chk_y_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

`ifdef SFU_SCHED_TIMEOUT_EN
  localparam int TW = clog2(PIPE_LAT + TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_INIT = TW'(PIPE_LAT + TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_hit, err_q;

  // DRAIN watchdog: reload on entry, count down to terminal count zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d == ST_DRAIN && state_q != ST_DRAIN) tmo_q <= TMO_INIT;
      else if (state_q == ST_DRAIN && tmo_q != '0)    tmo_q <= tmo_q - TW'(1);
      if (last_beat)    err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    pair_start = 1'b0;
    issue      = 1'b0;
`ifdef SFU_SCHED_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (last_beat) begin
          state_d    = ST_ISSUE;
          pair_start = 1'b1;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (last_pair) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (resp_cnt_q == NUM_PAIRS) state_d = ST_DONE;
`ifdef SFU_SCHED_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = ST_DONE;
          tmo_hit = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (accept) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // State register plus registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Entry buffer and load index.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx_q <= '0;
      for (int k = 0; k < NUM_ANT; k++) begin
        ent_data_q[k]  <= '0;
        ent_label_q[k] <= '0;
      end
    end else begin
      if (beat) begin
        ent_data_q[load_idx_q]  <= in_data;
        ent_label_q[load_idx_q] <= in_label;
        if (!last_beat) load_idx_q <= load_idx_q + IW'(1);
      end
      if (accept) load_idx_q <= '0;
    end
  end

  // Registered pair outputs toward the SFU-check stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid_q   <= 1'b0;
      chk_x_0_q     <= '0;
      chk_x_1_q     <= '0;
      chk_label_0_q <= '0;
      chk_label_1_q <= '0;
    end else begin
      chk_valid_q <= issue;
      if (issue) begin
        chk_x_0_q     <= ent_data_q[pi];
        chk_x_1_q     <= ent_data_q[pj];
        chk_label_0_q <= ent_label_q[pi];
        chk_label_1_q <= ent_label_q[pj];
      end
    end
  end

  // Result accumulation; cleared on the last load beat, frozen outside ISSUE/DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_cnt_q <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
    end else if (last_beat) begin
      resp_cnt_q <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
    end else if (capture) begin
      resp_cnt_q <= resp_cnt_q + CNT_W'(1);
      if (chk_flag_same_sfu) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        mask_q <= mask_q | (NUM_ANT'(1) << rsp_i) | (NUM_ANT'(1) << rsp_j);
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign chk_valid     = chk_valid_q;
  assign chk_x_0       = chk_x_0_q;
  assign chk_x_1       = chk_x_1_q;
  assign chk_label_0   = chk_label_0_q;
  assign chk_label_1   = chk_label_1_q;
  assign conflict_mask = mask_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_sfu_pair_sched.sv
// Directed bench for sfu_pair_sched with a behavioural SFU-check stage (PIPE_LAT = 1).
// Two labels share an SFU when they differ only in bit 0 (even base, base+1).
module tb_sfu_pair_sched;

  typedef logic [3:0] lab_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_label = '0;
  logic       chk_valid;
  logic [7:0] chk_x_0, chk_x_1;
  logic [3:0] chk_label_0, chk_label_1;
  logic       chk_y_valid = 1'b0;
  logic       chk_flag_same_sfu = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] conflict_mask;
  logic [4:0] conflict_cnt;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;
  int resp_limit = 1000;
  int sent = 0;

  always #5 clk = ~clk;

  sfu_pair_sched #(
    .DATA_WIDTH(8), .LABEL_WIDTH(4), .NUM_ANT(8), .PIPE_LAT(1), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_label(in_label),
    .chk_valid(chk_valid), .chk_x_0(chk_x_0), .chk_x_1(chk_x_1),
    .chk_label_0(chk_label_0), .chk_label_1(chk_label_1),
    .chk_y_valid(chk_y_valid), .chk_flag_same_sfu(chk_flag_same_sfu),
    .out_valid(out_valid), .out_ready(out_ready),
    .conflict_mask(conflict_mask), .conflict_cnt(conflict_cnt), .err(err)
  );

  function automatic logic same_sfu(input logic [3:0] a, input logic [3:0] b);
    return (a[3:1] == b[3:1]) && (a[0] != b[0]);
  endfunction

  function automatic logic [7:0] metric(input int k);
    return 8'h20 + 8'(k * 5);
  endfunction

  // SFU-check stage model; resp_limit can starve the scheduler of responses.
  always @(posedge clk) begin
    if (rst || in_ready) sent <= 0;
    else if (chk_valid)  sent <= sent + 1;
    chk_y_valid       <= chk_valid && (sent < resp_limit);
    chk_flag_same_sfu <= chk_valid && same_sfu(chk_label_0, chk_label_1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {in_ready, chk_valid, out_valid, err, chk_x_0, chk_x_1,
                chk_label_0, chk_label_1, conflict_mask, conflict_cnt}, 64'd0);
  endtask

  task automatic load_round(input lab_t lab);
    int cyc;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = metric(k);
      in_label = lab[k];
      cyc = 0;
      while (!in_ready && cyc < 100) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("load_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("in_ready_drop", in_ready, 0);
  endtask

  task automatic wait_result(input lab_t lab, input int exp_lat);
    int n, nchk, first, lastc;
    n = 0; nchk = 0; first = -1; lastc = -1;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (chk_valid) begin
        if (first < 0) first = n;
        lastc = n;
        if (nchk == 0)
          check("pair0_data", {chk_x_0, chk_x_1, chk_label_0, chk_label_1},
                {metric(0), metric(1), lab[0], lab[1]});
        if (nchk == 7)
          check("pair7_data", {chk_x_0, chk_x_1, chk_label_0, chk_label_1},
                {metric(1), metric(2), lab[1], lab[2]});
        nchk++;
      end
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("chk_cycles", 64'(nchk), 64'd28);
    check("chk_contig", 64'(lastc - first + 1), 64'd28);
  endtask

  task automatic check_result(input string tag, input logic [7:0] m, input logic [4:0] c,
                              input logic e);
    check(tag, {out_valid, conflict_mask, conflict_cnt, err}, {1'b1, m, c, e});
  endtask

  task automatic accept_and_check();
    @(posedge clk); #1;
    check("post_accept", {out_valid, in_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lab_t lab;
    int cyc;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst = 1'b0;

    lab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_distinct", 8'hFF, 5'd4, 1'b0);
    accept_and_check();

    lab = '{4'd0, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_one_pair", 8'h03, 5'd1, 1'b0);
    accept_and_check();

    lab = '{4'd15, 4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_wrap_odd", 8'h00, 5'd0, 1'b0);
    accept_and_check();

    out_ready = 1'b0;
    lab = '{4'd2, 4'd3, 4'd3, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_shared_i", 8'h07, 5'd2, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("backpressure_hold", {out_valid, in_ready, conflict_mask, conflict_cnt, err},
            {1'b1, 1'b0, 8'h07, 5'd2, 1'b0});
    end
    out_ready = 1'b1;
    accept_and_check();

    lab = '{4'd6, 4'd7, 4'd0, 4'd1, 4'd4, 4'd4, 4'd10, 4'd11};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_after_bp", 8'hCF, 5'd3, 1'b0);
    accept_and_check();

    lab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    load_round(lab);
    cyc = 0;
    while (cyc < 11 && sent < 200) begin
      @(posedge clk); #1;
      if (chk_valid) cyc++;
      if (!chk_valid && cyc > 0) break;
    end
    check("pair10_labels", {chk_valid, chk_label_0, chk_label_1}, {1'b1, 4'd1, 4'd5});
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_round_reset");
    rst = 1'b0;
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_after_reset", 8'hFF, 5'd4, 1'b0);
    accept_and_check();

`ifdef SFU_SCHED_TIMEOUT_EN
    resp_limit = 20;
    load_round(lab);
    wait_result(lab, 33);
    check_result("round_timeout", 8'h0F, 5'd2, 1'b1);
    resp_limit = 1000;
    accept_and_check();

    lab = '{4'd0, 4'd1, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    load_round(lab);
    wait_result(lab, 31);
    check_result("round_err_cleared", 8'h03, 5'd1, 1'b0);
    accept_and_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sfu_pair_sched.md
Name: sfu_pair_sched

Overview:
Controller that sequences the SFU-check datapath for one antenna-selection round.
- Loads NUM_ANT candidate antennas (metric, label) over a valid/ready stream.
- Issues every unordered pair (i<j) to the external SFU-check stage, one pair per cycle.
- Collects the same-SFU flags and reports a per-antenna conflict mask and a conflict-pair count.
- Sits between the candidate sorter and the final antenna selector.

Parameters:
- DATA_WIDTH, 8, antenna metric width (matches the SFU-check datapath)
- LABEL_WIDTH, 4, antenna label width
- NUM_ANT, 8, candidates per round; must be >= 2
- PIPE_LAT, 1, cycles from chk_valid to chk_y_valid in the SFU-check stage; must be >= 1
- TIMEOUT_CYC, 4, extra drain cycles before a timeout error (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  candidate entry valid
- in_ready  out  1  scheduler accepts an entry
- in_data  in  DATA_WIDTH  candidate metric
- in_label  in  LABEL_WIDTH  candidate label
- chk_valid  out  1  pair issued to SFU-check
- chk_x_0, chk_x_1  out  DATA_WIDTH  metrics of pair entries i and j
- chk_label_0, chk_label_1  out  LABEL_WIDTH  labels of entries i and j
- chk_y_valid  in  1  SFU-check result valid
- chk_flag_same_sfu  in  1  SFU-check result flag
- out_valid  out  1  round result valid
- out_ready  in  1  downstream accepts the result
- conflict_mask  out  NUM_ANT  bit k set if antenna k is in any flagged pair
- conflict_cnt  out  CNT_W  number of flagged pairs; CNT_W = clog2(NUM_ANT*(NUM_ANT-1)/2 + 1)
- err  out  1  timeout error flag (tied 0 without the optional feature)

Behaviour:
- Reset is synchronous and active-high on clk. Reset values:
  - in_ready = 0, chk_valid = 0, chk_* data and labels = 0
  - out_valid = 0, conflict_mask = 0, conflict_cnt = 0, err = 0
  - all counters and the entry buffer cleared; state goes to LOAD on the first cycle after reset.
- Reset mid-round aborts the round. Responses still in the SFU-check pipe are ignored after reset, because capture is enabled only in ISSUE and DRAIN.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready beat writes entry[load_idx] and increments load_idx.
  - After the beat with load_idx = NUM_ANT-1: go to ISSUE, clear mask, count and error.
  - in_ready drops in the cycle after that last beat.
- ISSUE:
  - Pair counters start at i=0, j=1. Each cycle drives chk_valid = 1 with entry[i] on port 0 and entry[j] on port 1 (registered outputs).
  - Advance rule: if j = NUM_ANT-1, then i++ and j = i+1; otherwise j++.
  - After pair (NUM_ANT-2, NUM_ANT-1) is issued: go to DRAIN with chk_valid = 0.
- Index tracking: a delay line PIPE_LAT deep carries (i, j) with each issue, aligned to chk_y_valid.
- Capture (ISSUE and DRAIN only): on chk_y_valid, resp_cnt++. If chk_flag_same_sfu = 1, set mask bits i and j and conflict_cnt++.
- DRAIN: when resp_cnt = NUM_ANT*(NUM_ANT-1)/2, go to DONE.
- DONE:
  - out_valid = 1; mask, count and err are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to LOAD next cycle (in_ready = 1 that cycle) and clear load_idx.
- Total latency from the last load beat to out_valid is P + PIPE_LAT + 2 cycles, where P = pair count.
- chk_y_valid outside ISSUE/DRAIN is ignored.
- A flag for a pair whose bits are already set does not change the mask but still increments the count.

Optional Feature:
SFU_SCHED_TIMEOUT_EN
- Defined: a DRAIN cycle counter runs. If responses are incomplete after PIPE_LAT + TIMEOUT_CYC cycles in DRAIN, go to DONE with err = 1 and the partial mask and count.
- Undefined: DRAIN waits indefinitely, no counter is instantiated, and err is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding (LOAD, ISSUE, DRAIN, DONE)
  - clog2 function
  - pair-count constant function NUM_ANT*(NUM_ANT-1)/2
- One natural sub-module, sfu_pair_idx_gen: the (i, j) pair counter with a last-pair flag, plus the PIPE_LAT index delay line.

Test Plan:
Bench uses the real SFU-check stage with LABEL_WIDTH = 4, PIPE_LAT = 1 and NUM_ANT = 8 (28 pairs).
- Labels {0,1,2,3,4,5,6,7}, out_ready = 1 -> 28 consecutive chk_valid cycles; conflict_mask = 0xFF, conflict_cnt = 4, out_valid 31 cycles after the last load beat.
- Labels {0,1,8,8,8,8,8,8} -> conflict_mask = 0x03, conflict_cnt = 1.
- Labels {15,0,5,5,5,5,5,5} (15+1 wraps to 0, odd base) -> conflict_mask = 0x00, conflict_cnt = 0.
- Labels {2,3,3,9,9,9,9,9} -> pairs (0,1) and (0,2) flagged; conflict_mask = 0x07, conflict_cnt = 2.
- Back-pressure and next round:
  - out_ready held low for 10 cycles -> outputs stable and in_ready = 0 throughout.
  - Then one accept beat -> in_ready = 1 next cycle; a second round loads correctly.
- Assert rst during ISSUE (pair 10) -> next cycle all outputs at reset values; a fresh round gives correct results.
- With SFU_SCHED_TIMEOUT_EN, drop all chk_y_valid after 20 responses -> err = 1 and out_valid after 5 DRAIN cycles.
